// File: rtl/red_pitaya_dac_slew_pkg.sv
// rtl/red_pitaya_dac_slew_pkg.sv - shared types, width default and step function for the DAC slew conditioner
package red_pitaya_dac_slew_pkg;

   localparam int DAC_DW = 14;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_RAMP_UP = 2'd1,
      ST_RUN     = 2'd2,
      ST_RAMP_DN = 2'd3
   } dac_state_t;

   // One bounded step from cur toward tgt; s == 0 jumps straight to tgt.
   // The result never leaves the [cur, tgt] interval, so no saturation is needed.
   function automatic logic signed [DAC_DW-1:0] move(
      input logic signed [DAC_DW-1:0] cur,
      input logic signed [DAC_DW-1:0] tgt,
      input logic        [DAC_DW-2:0] s
   );
      logic [DAC_DW:0] d;
      logic [DAC_DW:0] mag;
      d   = {tgt[DAC_DW-1], tgt} - {cur[DAC_DW-1], cur};
      mag = d[DAC_DW] ? (~d + (DAC_DW+1)'(1)) : d;
      if ((s == '0) || (mag <= {2'b00, s})) begin
         move = tgt;
      end else if (d[DAC_DW]) begin
         move = cur - {1'b0, s};
      end else begin
         move = cur + {1'b0, s};
      end
   endfunction

endpackage

// File: rtl/red_pitaya_dac_step.sv
// rtl/red_pitaya_dac_step.sv - combinational bounded step toward a target with reached/clipped flags
module red_pitaya_dac_step
   import red_pitaya_dac_slew_pkg::*;
#(
   parameter int DW = DAC_DW
) (
   input  logic signed [DW-1:0] cur,
   input  logic signed [DW-1:0] tgt,
   input  logic        [DW-2:0] step,
   output logic signed [DW-1:0] res,
   output logic                 reached,
   output logic                 clipped
);

   logic [DW:0] diff;
   logic [DW:0] mag;

   // Wide difference cannot overflow; the magnitude decides whether the step is clipped.
   always_comb begin
      diff    = {tgt[DW-1], tgt} - {cur[DW-1], cur};
      mag     = diff[DW] ? (~diff + (DW+1)'(1)) : diff;
      reached = (step == '0) || (mag <= {2'b00, step});
      clipped = ~reached;
      if (reached) begin
         res = tgt;
      end else if (diff[DW]) begin
         res = cur - {1'b0, step};
      end else begin
         res = cur + {1'b0, step};
      end
   end

endmodule

// File: rtl/red_pitaya_dac_slew.sv
// rtl/red_pitaya_dac_slew.sv - DAC slew limiter with soft start/stop; DAC_SLEW_STATS_EN adds a clip counter
module red_pitaya_dac_slew
   import red_pitaya_dac_slew_pkg::*;
#(
   parameter int DW = DAC_DW
) (
   input  logic                 dac_clk_i,
   input  logic                 dac_rst_i,
   input  logic signed [DW-1:0] dat_i,
   input  logic                 set_en_i,
   input  logic        [DW-2:0] set_slew_i,
   input  logic        [DW-2:0] set_ramp_i,
   output logic signed [DW-1:0] dac_o,
   output logic                 busy_o,
   output logic                 lim_o,
   output logic        [1:0]    state_o
`ifdef DAC_SLEW_STATS_EN
   ,
   input  logic                 stat_clr_i,
   output logic        [31:0]   lim_cnt_o
`endif
);

   dac_state_t          state, state_nxt;
   logic signed [DW-1:0] dat_r;
   logic signed [DW-1:0] dac_r, dac_nxt;
   logic                busy_r, busy_nxt;
   logic                lim_r, lim_nxt;

   logic        [DW-2:0] live_step;
   logic signed [DW-1:0] live_res, dn_res;
   logic                 live_reached, live_clipped;
   logic                 dn_reached, dn_clipped;

   // RUN is bounded by the slew limit, RAMP_UP by the ramp rate; both chase dat_r.
   assign live_step = (state == ST_RUN) ? set_slew_i : set_ramp_i;

   red_pitaya_dac_step #(.DW(DW)) u_step_live (
      .cur     (dac_r),
      .tgt     (dat_r),
      .step    (live_step),
      .res     (live_res),
      .reached (live_reached),
      .clipped (live_clipped)
   );

   red_pitaya_dac_step #(.DW(DW)) u_step_dn (
      .cur     (dac_r),
      .tgt     ('0),
      .step    (set_ramp_i),
      .res     (dn_res),
      .reached (dn_reached),
      .clipped (dn_clipped)
   );

   // Next state and next output sample; busy/lim describe the sample being produced.
   always_comb begin
      state_nxt = state;
      dac_nxt   = dac_r;
      busy_nxt  = 1'b0;
      lim_nxt   = 1'b0;
      case (state)
         ST_OFF: begin
            dac_nxt = '0;
            if (set_en_i) state_nxt = ST_RAMP_UP;
         end
         ST_RAMP_UP: begin
            dac_nxt  = live_res;
            busy_nxt = 1'b1;
            if (!set_en_i)         state_nxt = ST_RAMP_DN;
            else if (live_reached) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            dac_nxt = live_res;
            lim_nxt = live_clipped;
            if (!set_en_i) state_nxt = ST_RAMP_DN;
         end
         ST_RAMP_DN: begin
            dac_nxt  = dn_res;
            busy_nxt = 1'b1;
            if (set_en_i)        state_nxt = ST_RAMP_UP;
            else if (dn_reached) state_nxt = ST_OFF;
         end
         default: begin
            state_nxt = ST_OFF;
            dac_nxt   = '0;
         end
      endcase
   end

   // Input register, FSM state and output sample registers.
   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         state  <= ST_OFF;
         dat_r  <= '0;
         dac_r  <= '0;
         busy_r <= 1'b0;
         lim_r  <= 1'b0;
      end else begin
         state  <= state_nxt;
         dat_r  <= dat_i;
         dac_r  <= dac_nxt;
         busy_r <= busy_nxt;
         lim_r  <= lim_nxt;
      end
   end

   assign dac_o   = dac_r;
   assign busy_o  = busy_r;
   assign lim_o   = lim_r;
   assign state_o = state;

`ifdef DAC_SLEW_STATS_EN
   logic [31:0] lim_cnt;

   // Saturating count of clipped output samples; clear wins over increment.
   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         lim_cnt <= '0;
      end else if (stat_clr_i) begin
         lim_cnt <= '0;
      end else if (lim_r && (lim_cnt != 32'hFFFF_FFFF)) begin
         lim_cnt <= lim_cnt + 32'd1;
      end
   end

   assign lim_cnt_o = lim_cnt;
`else
   // No clip statistics in this build; the ramp-down clipped flag is not needed.
   logic unused_flags;
   assign unused_flags = dn_clipped;
`endif

`ifdef DAC_SLEW_STATS_EN
   logic unused_dn_clipped;
   assign unused_dn_clipped = dn_clipped;
`endif

endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// tb/tb_red_pitaya_dac_slew.sv - directed self-checking bench for red_pitaya_dac_slew
module tb_red_pitaya_dac_slew;

   logic               clk;
   logic               rst;
   logic signed [13:0] dat_i;
   logic               en;
   logic        [12:0] slew;
   logic        [12:0] ramp;
   logic signed [13:0] dac_o;
   logic               busy_o;
   logic               lim_o;
   logic        [1:0]  state_o;
`ifdef DAC_SLEW_STATS_EN
   logic               stat_clr;
   logic        [31:0] lim_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   red_pitaya_dac_slew #(.DW(14)) dut (
      .dac_clk_i  (clk),
      .dac_rst_i  (rst),
      .dat_i      (dat_i),
      .set_en_i   (en),
      .set_slew_i (slew),
      .set_ramp_i (ramp),
      .dac_o      (dac_o),
      .busy_o     (busy_o),
      .lim_o      (lim_o),
      .state_o    (state_o)
`ifdef DAC_SLEW_STATS_EN
      ,
      .stat_clr_i (stat_clr),
      .lim_cnt_o  (lim_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      n_tests++;
      if (dac_o !== 14'sd0 || busy_o !== 1'b0 || lim_o !== 1'b0 || state_o !== 2'd0) begin
         $display("FAIL reset_values dac=%0d busy=%b lim=%b state=%0d expected 0/0/0/0",
                  dac_o, busy_o, lim_o, state_o);
         n_fail++;
      end
   endtask

   task automatic test_soft_start();
      do_reset();
      ramp  = 13'd100;
      slew  = 13'd0;
      dat_i = 14'sd1000;
      tick();
      en = 1'b1;
      tick();
      n_tests++;
      if (state_o !== 2'd1 || dac_o !== 14'sd0) begin
         $display("FAIL start_enter state=%0d dac=%0d expected 1/0", state_o, dac_o);
         n_fail++;
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         n_tests++;
         if (dac_o !== 14'(100 * k) || busy_o !== 1'b1 || state_o !== ((k == 10) ? 2'd2 : 2'd1)) begin
            $display("FAIL start_step%0d dac=%0d busy=%b state=%0d expected %0d/1/%0d",
                     k, dac_o, busy_o, state_o, 100 * k, (k == 10) ? 2 : 1);
            n_fail++;
         end
      end
      tick();
      n_tests++;
      if (dac_o !== 14'sd1000 || busy_o !== 1'b0 || state_o !== 2'd2) begin
         $display("FAIL start_run dac=%0d busy=%b state=%0d expected 1000/0/2", dac_o, busy_o, state_o);
         n_fail++;
      end
   endtask

   task automatic test_slew_clip();
      slew  = 13'd0;
      dat_i = -14'sd8192;
      tick();
      tick();
      n_tests++;
      if (dac_o !== -14'sd8192 || lim_o !== 1'b0) begin
         $display("FAIL clip_floor dac=%0d lim=%b expected -8192/0", dac_o, lim_o);
         n_fail++;
      end
      slew  = 13'd50;
      dat_i = 14'sd8191;
      tick();
      for (int k = 1; k <= 327; k++) begin
         tick();
         n_tests++;
         if (dac_o !== 14'(-8192 + 50 * k) || lim_o !== 1'b1) begin
            $display("FAIL clip_step%0d dac=%0d lim=%b expected %0d/1", k, dac_o, lim_o, -8192 + 50 * k);
            n_fail++;
         end
      end
      tick();
      n_tests++;
      if (dac_o !== 14'sd8191 || lim_o !== 1'b0) begin
         $display("FAIL clip_final dac=%0d lim=%b expected 8191/0", dac_o, lim_o);
         n_fail++;
      end
   endtask

   task automatic test_soft_stop();
      int exp_v[3] = '{-477, -221, 0};
      slew  = 13'd0;
      dat_i = -14'sd733;
      tick();
      tick();
      n_tests++;
      if (dac_o !== -14'sd733 || state_o !== 2'd2) begin
         $display("FAIL stop_setup dac=%0d state=%0d expected -733/2", dac_o, state_o);
         n_fail++;
      end
      ramp = 13'd256;
      en   = 1'b0;
      tick();
      n_tests++;
      if (dac_o !== -14'sd733 || state_o !== 2'd3 || busy_o !== 1'b0) begin
         $display("FAIL stop_enter dac=%0d state=%0d busy=%b expected -733/3/0", dac_o, state_o, busy_o);
         n_fail++;
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++;
         if (dac_o !== 14'(exp_v[k]) || busy_o !== 1'b1 || state_o !== ((k == 2) ? 2'd0 : 2'd3)) begin
            $display("FAIL stop_step%0d dac=%0d busy=%b state=%0d expected %0d/1/%0d",
                     k, dac_o, busy_o, state_o, exp_v[k], (k == 2) ? 0 : 3);
            n_fail++;
         end
      end
      tick();
      n_tests++;
      if (dac_o !== 14'sd0 || busy_o !== 1'b0 || state_o !== 2'd0) begin
         $display("FAIL stop_off dac=%0d busy=%b state=%0d expected 0/0/0", dac_o, busy_o, state_o);
         n_fail++;
      end
   endtask

   task automatic test_reversal();
      do_reset();
      ramp  = 13'd0;
      slew  = 13'd0;
      dat_i = 14'sd1000;
      en    = 1'b1;
      tick();
      tick();
      n_tests++;
      if (dac_o !== 14'sd1000 || state_o !== 2'd2) begin
         $display("FAIL rev_setup dac=%0d state=%0d expected 1000/2", dac_o, state_o);
         n_fail++;
      end
      ramp = 13'd100;
      en   = 1'b0;
      tick();
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_tests++;
         if (dac_o !== 14'(1000 - 100 * k) || state_o !== 2'd3) begin
            $display("FAIL rev_down%0d dac=%0d state=%0d expected %0d/3", k, dac_o, state_o, 1000 - 100 * k);
            n_fail++;
         end
      end
      en = 1'b1;
      tick();
      n_tests++;
      if (dac_o !== 14'sd300 || state_o !== 2'd1 || busy_o !== 1'b1) begin
         $display("FAIL rev_turn dac=%0d state=%0d busy=%b expected 300/1/1", dac_o, state_o, busy_o);
         n_fail++;
      end
      for (int k = 1; k <= 7; k++) begin
         tick();
         n_tests++;
         if (dac_o !== 14'(300 + 100 * k) || state_o !== ((k == 7) ? 2'd2 : 2'd1)) begin
            $display("FAIL rev_up%0d dac=%0d state=%0d expected %0d/%0d",
                     k, dac_o, state_o, 300 + 100 * k, (k == 7) ? 2 : 1);
            n_fail++;
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      ramp  = 13'd100;
      slew  = 13'd0;
      dat_i = 14'sd100;
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      n_tests++;
      if (dac_o !== 14'sd100 || state_o !== 2'd3) begin
         $display("FAIL simul_drop dac=%0d state=%0d expected 100/3", dac_o, state_o);
         n_fail++;
      end
      en = 1'b1;
      tick();
      n_tests++;
      if (dac_o !== 14'sd0 || state_o !== 2'd1) begin
         $display("FAIL simul_rise dac=%0d state=%0d expected 0/1", dac_o, state_o);
         n_fail++;
      end
   endtask

   task automatic test_bypass();
      logic signed [13:0] hist[40];
      do_reset();
      ramp = 13'd0;
      slew = 13'd0;
      for (int k = 0; k < 40; k++) hist[k] = 14'($urandom);
      hist[3] = -14'sd8192;
      hist[4] = 14'sd8191;
      for (int k = 0; k <= 40; k++) begin
         if (k < 40) dat_i = hist[k];
         if (k == 0) en = 1'b1;
         tick();
         if (k >= 1) begin
            n_tests++;
            if (dac_o !== hist[k-1] || lim_o !== 1'b0) begin
               $display("FAIL bypass%0d dac=%0d lim=%b expected %0d/0", k, dac_o, lim_o, hist[k-1]);
               n_fail++;
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      ramp  = 13'd100;
      slew  = 13'd0;
      dat_i = 14'sd1000;
      en    = 1'b1;
      tick();
      tick();
      tick();
      tick();
      n_tests++;
      if (dac_o !== 14'sd300 || state_o !== 2'd1) begin
         $display("FAIL arst_setup dac=%0d state=%0d expected 300/1", dac_o, state_o);
         n_fail++;
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (dac_o !== 14'sd0 || state_o !== 2'd0 || busy_o !== 1'b0 || lim_o !== 1'b0) begin
         $display("FAIL arst_async dac=%0d state=%0d busy=%b lim=%b expected 0/0/0/0",
                  dac_o, state_o, busy_o, lim_o);
         n_fail++;
      end
`ifdef DAC_SLEW_STATS_EN
      n_tests++;
      if (lim_cnt !== 32'd0) begin
         $display("FAIL arst_cnt cnt=%0d expected 0", lim_cnt);
         n_fail++;
      end
      ramp  = 13'd0;
      dat_i = 14'sd0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      slew  = 13'd10;
      dat_i = 14'sd1000;
      tick();
      tick();
      n_tests++;
      if (dac_o !== 14'sd10 || lim_o !== 1'b1 || lim_cnt !== 32'd0) begin
         $display("FAIL stat_first dac=%0d lim=%b cnt=%0d expected 10/1/0", dac_o, lim_o, lim_cnt);
         n_fail++;
      end
      for (int k = 0; k < 4; k++) tick();
      n_tests++;
      if (lim_cnt !== 32'd4 || dac_o !== 14'sd50) begin
         $display("FAIL stat_count cnt=%0d dac=%0d expected 4/50", lim_cnt, dac_o);
         n_fail++;
      end
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      n_tests++;
      if (lim_cnt !== 32'd0 || lim_o !== 1'b1) begin
         $display("FAIL stat_clear cnt=%0d lim=%b expected 0/1", lim_cnt, lim_o);
         n_fail++;
      end
`else
      tick();
      rst = 1'b0;
`endif
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      dat_i = '0;
      slew  = '0;
      ramp  = '0;
`ifdef DAC_SLEW_STATS_EN
      stat_clr = 1'b0;
`endif
      test_reset();
      test_soft_start();
      test_slew_clip();
      test_soft_stop();
      test_reversal();
      test_simultaneous();
      test_bypass();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
